// File: rtl/conv_pool_requant.sv
// Streaming requantize (shift + saturate to 8 bits) followed by non-overlapping
// Pool_Dim x Pool_Dim max-pooling of a raster-ordered In_Dim x In_Dim map.
module conv_pool_requant #(
  parameter int In_Dim   = 2,
  parameter int Pool_Dim = 2,
  parameter int Shift    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        frame_done
);
  localparam int NW  = In_Dim / Pool_Dim;
  localparam int PCW = (Pool_Dim > 1) ? $clog2(Pool_Dim) : 1;
  localparam int WW  = (NW > 1) ? $clog2(NW) : 1;
  localparam int ND  = 1 << WW;
  localparam logic [PCW-1:0] P_LAST = PCW'(Pool_Dim - 1);
  localparam logic [WW-1:0]  W_LAST = WW'(NW - 1);

  if (Pool_Dim < 1 || (In_Dim % Pool_Dim) != 0) begin : g_bad_dim
    $error("conv_pool_requant: In_Dim must be a positive multiple of Pool_Dim");
  end
  if (Shift < 0 || Shift > 15) begin : g_bad_shift
    $error("conv_pool_requant: Shift must be in 0..15");
  end

  // Column/row are kept as (window index, offset inside window) pairs so the
  // window-start and emit tests need no modulo hardware.
  logic [PCW-1:0]     pc_q, pc_d, pr_q, pr_d;
  logic [WW-1:0]      wc_q, wc_d, wr_q, wr_d;
  logic [ND-1:0][7:0] part_q, part_d;
  logic [7:0]         out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               frame_done_q, frame_done_d;

  logic [15:0] shifted;
  logic [7:0]  q, cur, upd;
  logic        win_start, emit, last_pos;

  assign shifted = in_data >> Shift;
  assign q       = (|shifted[15:8]) ? 8'hFF : shifted[7:0];

  always_comb begin
    cur       = part_q[wc_q];
    win_start = (pc_q == '0) && (pr_q == '0);
    emit      = (pc_q == P_LAST) && (pr_q == P_LAST);
    last_pos  = emit && (wc_q == W_LAST) && (wr_q == W_LAST);
    // With Pool_Dim=1 every sample is both window start and emit, so upd = q.
    upd       = win_start ? q : ((cur > q) ? cur : q);
  end

  always_comb begin
    pc_d         = pc_q;
    pr_d         = pr_q;
    wc_d         = wc_q;
    wr_d         = wr_q;
    part_d       = part_q;
    out_data_d   = out_data_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (in_valid) begin
      part_d[wc_q] = upd;
      if (emit) begin
        out_data_d   = upd;
        out_valid_d  = 1'b1;
        frame_done_d = last_pos;
      end
      if (pc_q == P_LAST) begin
        pc_d = '0;
        if (wc_q == W_LAST) begin
          wc_d = '0;
          if (pr_q == P_LAST) begin
            pr_d = '0;
            wr_d = (wr_q == W_LAST) ? '0 : wr_q + 1'b1;
          end else begin
            pr_d = pr_q + 1'b1;
          end
        end else begin
          wc_d = wc_q + 1'b1;
        end
      end else begin
        pc_d = pc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q         <= '0;
      pr_q         <= '0;
      wc_q         <= '0;
      wr_q         <= '0;
      part_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      pr_q         <= pr_d;
      wc_q         <= wc_d;
      wr_q         <= wr_d;
      part_q       <= part_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_conv_pool_requant.sv
// Bench for conv_pool_requant: table of stimulus records with constant expected
// pooled values, scoreboard queue checked against the output stream.
module tb_conv_pool_requant;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic [1:0]  sel = '0;

  logic [7:0] d0, d1, d2;
  logic       v0, v1, v2, f0, f1, f2;

  always #5 clk = ~clk;

  // 0: 4x4 pool 2 shift 4; 1: 4x4 pool 2 shift 0; 2: 2x2 pool 1 shift 1
  conv_pool_requant #(.In_Dim(4), .Pool_Dim(2), .Shift(4)) u_dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid && sel == 2'd0),
    .out_data(d0), .out_valid(v0), .frame_done(f0));
  conv_pool_requant #(.In_Dim(4), .Pool_Dim(2), .Shift(0)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid && sel == 2'd1),
    .out_data(d1), .out_valid(v1), .frame_done(f1));
  conv_pool_requant #(.In_Dim(2), .Pool_Dim(1), .Shift(1)) u_dut2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid && sel == 2'd2),
    .out_data(d2), .out_valid(v2), .frame_done(f2));

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] data;
    logic        valid;
    logic        emit;
    logic [7:0]  exp_d;
    logic        exp_fd;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       fd;
    logic       from0;
    int         due;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   ncyc = 0;
  logic [7:0] last0 = '0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (cycle %0d)", nm, act, req, ncyc);
    end
  endtask

  function automatic void add(logic [1:0] s, logic [15:0] d, logic v, logic em,
                              logic [7:0] ed, logic ef);
    vec_t r;
    r.sel = s; r.data = d; r.valid = v; r.emit = em; r.exp_d = ed; r.exp_fd = ef;
    vecs.push_back(r);
  endfunction

  function automatic void add_idle(logic [1:0] s, int n);
    for (int i = 0; i < n; i++) add(s, 16'hFFFF, 1'b0, 1'b0, 8'd0, 1'b0);
  endfunction

  // 4x4 frame, value base+step*k (optionally one override), pool-2 emits at
  // raster indices 5, 7, 13, 15 with the given expected outputs.
  function automatic void add_frame(logic [1:0] s, int base, int step, int gap,
                                    int ov_k, int ov_v, int e0, int e1, int e2, int e3);
    int ev[4];
    int j;
    ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
    j = 0;
    for (int k = 0; k < 16; k++) begin
      logic [15:0] v;
      logic em;
      v  = (k == ov_k) ? 16'(ov_v) : 16'(base + step * k);
      em = (k == 5) || (k == 7) || (k == 13) || (k == 15);
      add(s, v, 1'b1, em, em ? 8'(ev[j]) : 8'd0, em && (j == 3));
      if (em) j++;
      add_idle(s, gap);
    end
  endfunction

  task automatic drive(vec_t v);
    sel      = v.sel;
    in_data  = v.data;
    in_valid = v.valid;
    if (v.valid && v.emit) begin
      exp_t e;
      e.d = v.exp_d; e.fd = v.exp_fd; e.from0 = (v.sel == 2'd0); e.due = ncyc + 2;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Output monitor: the three instances are never active together.
  logic       mv, mf;
  logic [7:0] md;
  exp_t       me;
  always @(negedge clk) begin
    ncyc = ncyc + 1;
    mv = v0 | v1 | v2;
    mf = f0 | f1 | f2;
    md = v0 ? d0 : (v1 ? d1 : d2);
    if (!rst) begin
      last0 = '0;
    end else begin
      if (mv) begin
        if (sbq.size() == 0) begin
          chk("unexpected_pulse", 32'(md), 32'hFFFF_FFFF);
        end else begin
          me = sbq.pop_front();
          chk("out_data", 32'(md), 32'(me.d));
          chk("frame_done", 32'(mf), 32'(me.fd));
          chk("latency_cycle", 32'(ncyc), 32'(me.due));
          if (me.from0) last0 = me.d;
        end
      end else begin
        if (sbq.size() > 0 && sbq[0].due <= ncyc) begin
          me = sbq.pop_front();
          chk("missing_pulse", 32'(mv), 32'd1);
        end
        chk("frame_done_idle", 32'(mf), 32'd0);
      end
      if (!v0) chk("hold_out_data", 32'(d0), 32'(last0));
    end
  end

  initial begin
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_data0", 32'(d0), 0);  chk("rst_out_valid0", 32'(v0), 0);
    chk("rst_frame_done0", 32'(f0), 0);
    chk("rst_out_data1", 32'(d1), 0);  chk("rst_out_valid1", 32'(v1), 0);
    chk("rst_out_data2", 32'(d2), 0);  chk("rst_out_valid2", 32'(v2), 0);
    @(negedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    add_frame(2'd0, 0, 16, 0, -1, 0, 5, 7, 13, 15);          // basic
    add_frame(2'd0, 0, 16, 2, -1, 0, 5, 7, 13, 15);          // gapped 1,0,0
    add_frame(2'd0, 0, 16, 0, -1, 0, 5, 7, 13, 15);          // back-to-back
    add_frame(2'd0, 16, 16, 0, -1, 0, 6, 8, 14, 16);
    add_frame(2'd0, 0, 0, 0, 0, 16'hFFFF, 255, 0, 0, 0);     // q=4095 saturates
    add_idle(2'd0, 2);
    add_frame(2'd1, 300, 0, 0, 6, 16'h0010, 255, 255, 255, 255);
    add_frame(2'd1, 0, 1, 1, -1, 0, 5, 7, 13, 15);
    add_idle(2'd1, 2);
    for (int f = 0; f < 2; f++) begin                         // Pool_Dim=1
      add(2'd2, 16'd2,   1'b1, 1'b1, 8'd1,   1'b0);
      add(2'd2, 16'd4,   1'b1, 1'b1, 8'd2,   1'b0);
      add(2'd2, 16'd6,   1'b1, 1'b1, 8'd3,   1'b0);
      add(2'd2, 16'd600, 1'b1, 1'b1, 8'd255, 1'b1);
    end
    add_idle(2'd2, 3);
    for (int i = 0; i < vecs.size(); i++) drive(vecs[i]);

    // Reset mid-frame after 6 inputs; outputs clear asynchronously.
    vecs.delete();
    add_frame(2'd0, 0, 16, 0, -1, 0, 5, 7, 13, 15);
    for (int i = 0; i < 6; i++) drive(vecs[i]);
    @(negedge clk); #1 rst = 1'b0;
    #1;
    chk("midrst_out_data", 32'(d0), 0);
    chk("midrst_out_valid", 32'(v0), 0);
    chk("midrst_frame_done", 32'(f0), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) drive(vecs[i]);

    vecs.delete();
    add_idle(2'd0, 4);
    for (int i = 0; i < vecs.size(); i++) drive(vecs[i]);
    chk("scoreboard_drained", 32'(sbq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
